// File: rtl/obstacle_spawner_if.sv
// Obstacle spawner bus: game-state and step inputs from the game controller,
// plus the two obstacle slots and event pulses returned to game logic/renderer.
// The controller side uses the master modport; obstacle_spawner uses slave.
interface obstacle_spawner_if;
    logic       obsClk;     // single-cycle obstacle step pulse
    logic [3:0] gameState;  // MENU=0000, RUNNING=0011, PAUSE=1111, OVER=0010
    logic [7:0] obs1X;
    logic [7:0] obs1H;
    logic [7:0] obs2X;
    logic [7:0] obs2H;
    logic       spawn;      // one-cycle pulse: a slot respawned
    logic       cleared;    // one-cycle pulse: a slot reached CLEAR_X

    modport master (
        output obsClk, gameState,
        input  obs1X, obs1H, obs2X, obs2H, spawn, cleared
    );

    modport slave (
        input  obsClk, gameState,
        output obs1X, obs1H, obs2X, obs2H, spawn, cleared
    );
endinterface

// File: rtl/obstacle_spawner.sv
// obstacle_spawner: owns the two obstacle slots (X, height). Each step pulse
// in RUNNING scrolls both slots left by one; a slot sitting at X=0 respawns
// to the right of the other slot with an LFSR-derived gap and height.
// Optional feature macro: OBS_LFSR_FREERUN_EN -- when defined the LFSR
// advances every clock (only the async reset seeds it), so obstacle
// sequences depend on player timing instead of being fixed per seed.
module obstacle_spawner #(
    parameter logic [7:0]  SPAWN_X   = 8'd160,   // one past right screen edge
    parameter logic [7:0]  MIN_GAP   = 8'd40,    // min separation from other slot
    parameter logic [7:0]  MIN_H     = 8'd7,     // heights span MIN_H..MIN_H+7
    parameter logic [7:0]  CLEAR_X   = 8'd3,     // obstacle fully past the dino
    parameter logic [7:0]  INIT1_X   = 8'd120,
    parameter logic [7:0]  INIT1_H   = 8'd7,
    parameter logic [7:0]  INIT2_X   = 8'd254,
    parameter logic [7:0]  INIT2_H   = 8'd14,
    parameter logic [15:0] LFSR_SEED = 16'hACE1  // must be nonzero
) (
    input  logic              clk,
    input  logic              resetn,
    obstacle_spawner_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,   // menu: hold everything at its start values
        ST_RUN,    // game running: obsClk steps the slots
        ST_HOLD    // pause, game over or unknown code: freeze
    } state_t;

    // The mode follows gameState directly, so a change of gameState takes
    // effect on the very next clock edge; there is no extra state latency.
    state_t      w_state;

    logic [7:0]  r_obs1x, r_obs1h, r_obs2x, r_obs2h;
    logic [15:0] r_lfsr;
    logic        r_spawn, r_cleared;

    logic [7:0]  w_obs1x_next, w_obs1h_next, w_obs2x_next, w_obs2h_next;
    logic [15:0] w_lfsr_next;
    logic        w_spawn_next, w_cleared_next;

    logic        w_step;
    logic        w_respawn1, w_respawn2;
    logic [7:0]  w_dec1, w_dec2;
    logic [15:0] w_lfsr_adv;

    // Respawn X: max(SPAWN_X, other+MIN_GAP) + rnd, computed wide enough
    // that no parameter choice can wrap, then clamped to the 8-bit screen range.
    function automatic logic [7:0] f_spawn_x(input logic [7:0] other_x,
                                             input logic [4:0] rnd);
        logic [9:0] gap_sum;
        logic [9:0] base;
        logic [9:0] total;
        gap_sum = {2'b00, other_x} + {2'b00, MIN_GAP};
        base    = (gap_sum > {2'b00, SPAWN_X}) ? gap_sum : {2'b00, SPAWN_X};
        total   = base + {5'b00000, rnd};
        return (total > 10'd255) ? 8'd255 : total[7:0];
    endfunction

    // Decode the game mode from gameState every cycle.
    always_comb begin
        w_state = ST_HOLD;
        case (bus.gameState)
            4'b0000: w_state = ST_IDLE;
            4'b0011: w_state = ST_RUN;
            default: w_state = ST_HOLD;
        endcase
    end

    assign w_step     = (w_state == ST_RUN) && bus.obsClk;
    assign w_dec1     = r_obs1x - 8'd1;
    assign w_dec2     = r_obs2x - 8'd1;
    assign w_lfsr_adv = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    // Slot 1 wins a simultaneous X=0; slot 2 then waits at 0 for one step so
    // it respawns against slot 1's fresh X and the LFSR moves once per step.
    assign w_respawn1 = (r_obs1x == 8'd0);
    assign w_respawn2 = (r_obs2x == 8'd0) && !w_respawn1;

    // Next-state logic for slots, pulses and LFSR per mode.
    always_comb begin
        w_obs1x_next   = r_obs1x;
        w_obs1h_next   = r_obs1h;
        w_obs2x_next   = r_obs2x;
        w_obs2h_next   = r_obs2h;
        w_spawn_next   = 1'b0;
        w_cleared_next = 1'b0;

        case (w_state)
            ST_IDLE: begin
                w_obs1x_next = INIT1_X;
                w_obs1h_next = INIT1_H;
                w_obs2x_next = INIT2_X;
                w_obs2h_next = INIT2_H;
            end
            ST_RUN: begin
                if (w_step) begin
                    if (w_respawn1) begin
                        w_obs1x_next = f_spawn_x(r_obs2x, r_lfsr[4:0]);
                        w_obs1h_next = MIN_H + {5'b00000, r_lfsr[2:0]};
                    end else begin
                        w_obs1x_next = w_dec1;
                    end

                    if (w_respawn2) begin
                        w_obs2x_next = f_spawn_x(r_obs1x, r_lfsr[4:0]);
                        w_obs2h_next = MIN_H + {5'b00000, r_lfsr[2:0]};
                    end else if (r_obs2x != 8'd0) begin
                        w_obs2x_next = w_dec2;
                    end

                    w_spawn_next   = w_respawn1 || w_respawn2;
                    w_cleared_next = ((r_obs1x != 8'd0) && (w_dec1 == CLEAR_X)) ||
                                     ((r_obs2x != 8'd0) && (w_dec2 == CLEAR_X));
                end
            end
            default: ; // frozen
        endcase

`ifdef OBS_LFSR_FREERUN_EN
        // Free-running: moves every clock regardless of mode.
        w_lfsr_next = w_lfsr_adv;
`else
        // Deterministic: reseeded in the menu, moves only when a slot respawns.
        w_lfsr_next = r_lfsr;
        if (w_state == ST_IDLE) begin
            w_lfsr_next = LFSR_SEED;
        end else if (w_step && (w_respawn1 || w_respawn2)) begin
            w_lfsr_next = w_lfsr_adv;
        end
`endif
    end

    // State registers; the async reset lands on the same values as the menu.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_obs1x   <= INIT1_X;
            r_obs1h   <= INIT1_H;
            r_obs2x   <= INIT2_X;
            r_obs2h   <= INIT2_H;
            r_lfsr    <= LFSR_SEED;
            r_spawn   <= 1'b0;
            r_cleared <= 1'b0;
        end else begin
            r_obs1x   <= w_obs1x_next;
            r_obs1h   <= w_obs1h_next;
            r_obs2x   <= w_obs2x_next;
            r_obs2h   <= w_obs2h_next;
            r_lfsr    <= w_lfsr_next;
            r_spawn   <= w_spawn_next;
            r_cleared <= w_cleared_next;
        end
    end

    assign bus.obs1X   = r_obs1x;
    assign bus.obs1H   = r_obs1h;
    assign bus.obs2X   = r_obs2x;
    assign bus.obs2H   = r_obs2h;
    assign bus.spawn   = r_spawn;
    assign bus.cleared = r_cleared;

endmodule
